// File: rtl/pipe_mdu_ctrl.sv
// rtl/pipe_mdu_ctrl.sv - iterative multiply/divide sequencer with HI/LO registers and ID stall
module pipe_mdu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             nostall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mag_a, mag_b, a_lat;
    logic [WIDTH-1:0] acc_hi, acc_lo;   // multiply: product halves; divide: rem / quo
    logic             neg_q, neg_r, dz, is_div;
    logic [CNTW-1:0]  count;

    logic             start_acc;
    logic             signed_op;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             trial_ok;
    logic [WIDTH-1:0] trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Any HI/LO or new-op access while the unit is busy must wait in ID
    assign nostall   = ~(busy & (start | rd_hilo | wr_hi | wr_lo));
    assign start_acc = (state == IDLE) & start & nostall;
    assign signed_op = op[0];

    // One radix-2 step of each datapath plus the sign fix-up applied in FIX
    always_comb begin
        mul_sum  = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, mag_a}) : {1'b0, acc_hi};
        rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
        trial_ok = (rem_sh >= {1'b0, mag_b});
        // when the trial succeeds the difference is below mag_b, so WIDTH bits suffice
        trial    = rem_sh[WIDTH-1:0] - mag_b;
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -acc_lo : acc_lo;
        rem_fix  = neg_r ? -acc_hi : acc_hi;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE -> RUN on accepted start, RUN for WIDTH cycles, one FIX cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = RUN;
            RUN:     if (count == CNTW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration datapath, HI/LO writes and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            a_lat  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            is_div <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        mag_a  <= (signed_op & a[WIDTH-1]) ? -a : a;
                        mag_b  <= (signed_op & b[WIDTH-1]) ? -b : b;
                        a_lat  <= a;
                        neg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= signed_op & a[WIDTH-1];
                        dz     <= op[1] & (b == '0);
                        is_div <= op[1];
                        count  <= '0;
                        busy   <= 1'b1;
                        acc_hi <= '0;
                        // multiplier shifts out of acc_lo; dividend shifts out of quo
                        if (op[1]) acc_lo <= (signed_op & a[WIDTH-1]) ? -a : a;
                        else       acc_lo <= (signed_op & b[WIDTH-1]) ? -b : b;
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                RUN: begin
                    count <= count + CNTW'(1);
                    if (is_div) begin
                        acc_hi <= trial_ok ? trial : rem_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], trial_ok};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (dz) begin
                            lo <= '1;
                            hi <= a_lat;
                        end else begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// tb/tb_pipe_mdu_ctrl.sv - self-checking bench for pipe_mdu_ctrl
module tb_pipe_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, rd_hilo, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, nostall;

    int checks = 0;
    int errors = 0;

    pipe_mdu_ctrl #(.WIDTH(32), .CNTW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .rd_hilo(rd_hilo), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .nostall(nostall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the architectural definition of each op
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] mh, output logic [31:0] ml);
        logic [63:0] p;
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        mh = '0;
        ml = '0;
        if (o == 2'd0) begin
            p  = {32'd0, x} * {32'd0, y};
            mh = p[63:32];
            ml = p[31:0];
        end else if (o == 2'd1) begin
            q  = sx * sy;
            mh = q[63:32];
            ml = q[31:0];
        end else if (y == 32'd0) begin
            mh = x;
            ml = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
            ml = x / y;
            mh = x % y;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            ml = q[31:0];
            mh = r[31:0];
        end
    endfunction

    // Issue one op; scramble a/b/op while busy; return in the cycle after the final edge
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int bcyc, output int dones, output logic [31:0] oh, output logic [31:0] ol);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        bcyc = 0;
        dones = 0;
        while (busy && bcyc < 100) begin
            bcyc++;
            if (done) dones++;
            a = $urandom; b = $urandom; op = 2'($urandom_range(3));
            tick();
        end
        if (done) dones++;
        if (bcyc >= 100) begin
            checks++; errors++;
            $display("FAIL op_timeout busy=%0b after %0d cycles, required busy=0", busy, bcyc);
        end
        oh = hi;
        ol = lo;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; op = 0; a = 0; b = 0; rd_hilo = 0; wr_hi = 0; wr_lo = 0; wdata = 0;
        tick(); tick();
        rst = 1'b0;
        rd_hilo = 1'b1;
        #1;
        checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (nostall !== 1'b1) begin errors++; $display("FAIL reset_nostall got %b want 1", nostall); end
        rd_hilo = 1'b0;
    endtask

    task automatic test_mult();
        logic [31:0] xs[2], ys[2], eh, el, oh, ol;
        logic [1:0]  os[2];
        int bc, dn;
        os[0] = 2'd1; xs[0] = 32'hFFFF_FFFD; ys[0] = 32'd5;
        os[1] = 2'd0; xs[1] = 32'hFFFF_FFFF; ys[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            model(os[i], xs[i], ys[i], eh, el);
            do_op(os[i], xs[i], ys[i], bc, dn, oh, ol);
            checks++; if (oh !== eh) begin errors++; $display("FAIL mult_hi[%0d] got %h want %h", i, oh, eh); end
            checks++; if (ol !== el) begin errors++; $display("FAIL mult_lo[%0d] got %h want %h", i, ol, el); end
            checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles[%0d] got %0d want 33", i, bc); end
            checks++; if (dn !== 1 || done !== 1'b1) begin errors++; $display("FAIL mult_done[%0d] got pulses=%0d done=%b want 1,1", i, dn, done); end
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_width[%0d] got %b want 0", i, done); end
        end
    endtask

    task automatic test_div();
        logic [31:0] xs[5], ys[5], eh, el, oh, ol;
        logic [1:0]  os[5];
        int bc, dn;
        os[0] = 2'd2; xs[0] = 32'd100;         ys[0] = 32'd7;
        os[1] = 2'd3; xs[1] = 32'hFFFF_FFF9;   ys[1] = 32'd2;
        os[2] = 2'd3; xs[2] = 32'h8000_0000;   ys[2] = 32'hFFFF_FFFF;
        os[3] = 2'd3; xs[3] = 32'h1234_5678;   ys[3] = 32'd0;
        os[4] = 2'd2; xs[4] = 32'h9ABC_DEF0;   ys[4] = 32'd0;
        for (int i = 0; i < 5; i++) begin
            model(os[i], xs[i], ys[i], eh, el);
            do_op(os[i], xs[i], ys[i], bc, dn, oh, ol);
            checks++; if (oh !== eh) begin errors++; $display("FAIL div_hi[%0d] got %h want %h", i, oh, eh); end
            checks++; if (ol !== el) begin errors++; $display("FAIL div_lo[%0d] got %h want %h", i, ol, el); end
            checks++; if (bc !== 33 || dn !== 1) begin errors++; $display("FAIL div_timing[%0d] got busy=%0d pulses=%0d want 33,1", i, bc, dn); end
            tick();
        end
    endtask

    task automatic test_hilo_write();
        logic [31:0] eh, el, oh, ol;
        int bc, dn;
        wr_hi = 1'b1; wdata = 32'hA5A5_A5A5;
        tick();
        wr_hi = 1'b0;
        checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi got %h want a5a5a5a5", hi); end
        wr_lo = 1'b1; wdata = 32'h5A5A_0001;
        tick();
        wr_lo = 1'b0;
        checks++; if (lo !== 32'h5A5A_0001 || hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mtlo got hi=%h lo=%h want a5a5a5a5 5a5a0001", hi, lo); end
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0F0F_1234;
        tick();
        checks++; if (hi !== 32'h0F0F_1234 || lo !== 32'h0F0F_1234) begin errors++; $display("FAIL mthi_mtlo got hi=%h lo=%h want 0f0f1234", hi, lo); end
        // start in the same cycle as writes: writes are dropped
        wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = 2'd2; a = 32'd50; b = 32'd8;
        tick();
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        checks++; if (hi !== 32'h0F0F_1234 || lo !== 32'h0F0F_1234) begin errors++; $display("FAIL start_drops_write got hi=%h lo=%h want 0f0f1234", hi, lo); end
        bc = 0;
        while (busy && bc < 100) begin bc++; tick(); end
        model(2'd2, 32'd50, 32'd8, eh, el);
        oh = hi; ol = lo; dn = 0;
        checks++; if (oh !== eh || ol !== el || bc !== 33) begin errors++; $display("FAIL start_with_write_result got hi=%h lo=%h busy=%0d want %h %h 33", oh, ol, bc, eh, el); end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] x, y, eh, el;
        int n, bad;
        x = $urandom; y = $urandom;
        model(2'd0, x, y, eh, el);
        rd_hilo = 1'b1;
        #1;
        checks++; if (nostall !== 1'b1) begin errors++; $display("FAIL stall_idle got nostall=%b want 1", nostall); end
        rd_hilo = 1'b0;
        start = 1'b1; op = 2'd0; a = x; b = y;
        tick();
        start = 1'b0;
        n = 0; bad = 0;
        while (busy && n < 100) begin
            rd_hilo = (n % 4 == 0); wr_hi = (n % 4 == 1); wr_lo = (n % 4 == 2); start = (n % 4 == 3);
            wdata = $urandom;
            #1;
            if (nostall !== 1'b0) bad++;
            n++;
            tick();
        end
        checks++; if (bad !== 0 || n !== 33) begin errors++; $display("FAIL stall_busy got bad=%0d cycles=%0d want 0,33", bad, n); end
        checks++; if (nostall !== 1'b1) begin errors++; $display("FAIL stall_release got nostall=%b want 1", nostall); end
        rd_hilo = 0; wr_hi = 0; wr_lo = 0; start = 0;
        checks++; if (hi !== eh || lo !== el) begin errors++; $display("FAIL stall_result got hi=%h lo=%h want %h %h", hi, lo, eh, el); end
        tick();
        checks++; if (nostall !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_after got nostall=%b busy=%b want 1,0", nostall, busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] oh, ol;
        int bc, dn, seen;
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1357_9BDF;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        start = 1'b1; op = 2'd0; a = 32'h0000_1234; b = 32'h0000_5678;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_quiet got %0d active cycles want 0", seen); end
        do_op(2'd2, 32'd9, 32'd3, bc, dn, oh, ol);
        checks++; if (ol !== 32'd3 || oh !== 32'd0) begin errors++; $display("FAIL reset_mid_divu got hi=%h lo=%h want 0 3", oh, ol); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh, el, oh, ol;
        int bc, dn;
        do_op(2'd1, 32'h8000_0000, 32'h8000_0000, bc, dn, oh, ol);
        model(2'd1, 32'h8000_0000, 32'h8000_0000, eh, el);
        checks++; if (oh !== eh || ol !== el) begin errors++; $display("FAIL b2b_first got hi=%h lo=%h want %h %h", oh, ol, eh, el); end
        checks++; if (done !== 1'b1 || nostall !== 1'b1) begin errors++; $display("FAIL b2b_gap got done=%b nostall=%b want 1,1", done, nostall); end
        do_op(2'd3, 32'hFFFF_FF85, 32'hFFFF_FFF6, bc, dn, oh, ol);
        model(2'd3, 32'hFFFF_FF85, 32'hFFFF_FFF6, eh, el);
        checks++; if (oh !== eh || ol !== el || bc !== 33 || dn !== 1) begin errors++; $display("FAIL b2b_second got hi=%h lo=%h busy=%0d pulses=%0d want %h %h 33 1", oh, ol, bc, dn, eh, el); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] x, y, eh, el, oh, ol;
        logic [1:0]  o;
        int bc, dn, sel;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(3));
            x = $urandom;
            sel = $urandom_range(9);
            if (sel == 0)      y = 32'd0;
            else if (sel < 4)  y = 32'($urandom_range(15));
            else if (sel == 4) y = 32'hFFFF_FFFF;
            else               y = $urandom;
            if (sel == 5) x = 32'h8000_0000;
            model(o, x, y, eh, el);
            do_op(o, x, y, bc, dn, oh, ol);
            checks++;
            if (oh !== eh || ol !== el || bc !== 33 || dn !== 1) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got hi=%h lo=%h busy=%0d pulses=%0d want %h %h 33 1",
                         i, o, x, y, oh, ol, bc, dn, eh, el);
            end
            if (i % 2 == 1) tick();
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_hilo_write();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
